// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 pipeline: constants and pipeline register payloads.
package cpu_pkg;

  localparam int unsigned PC_W_DEF    = 64;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam logic [31:0] BUBBLE_INSTR = 32'hD503201F;
  localparam logic [63:0] PC_INC       = 64'd4;

  typedef struct packed {
    logic                   valid;
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
    logic [PC_W_DEF-1:0]    pc_plus4;
  } ifid_t;

  // Bubble contents: invalid slot carrying a NOP so decode sees a harmless instruction.
  localparam ifid_t IFID_BUBBLE = '{
    valid:    1'b0,
    instr:    BUBBLE_INSTR,
    pc:       '0,
    pc_plus4: '0
  };

endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register: clear wins over enable; clear and reset load the bubble value.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter type T       = ifid_t,
  parameter T    RST_VAL = IFID_BUBBLE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  T     d,
  output T     q
);

  T q_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= RST_VAL;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select and the IF/ID pipeline register.
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [PC_W-1:0]    pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus4,
  output logic [31:0]        fetch_count
);

  logic [PC_W-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            squash, load;
  ifid_t           ifid_d, ifid_q;

  assign pc_plus4 = pc_q + PC_INC[PC_W-1:0];
  assign squash   = redirect | flush;
  assign load     = ~squash & ~stall;

  // Redirect targets are word-aligned by force; a redirect overrides a stall.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_comb begin
    ifid_d.valid    = 1'b1;
    ifid_d.instr    = imem_instr;
    ifid_d.pc       = pc_q;
    ifid_d.pc_plus4 = pc_plus4;
  end

  ifid_reg #(
    .T       (ifid_t),
    .RST_VAL (IFID_BUBBLE)
  ) u_ifid_reg (
    .clk (clk),
    .rst (rst),
    .en  (~stall),
    .clr (squash),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  assign fetch_count_d = load ? fetch_count_q + 32'd1 : fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign ifid_valid    = ifid_q.valid;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: reference model checked every cycle plus directed literal checks.
module tb_if_stage;

  localparam logic [31:0] BUBBLE = 32'hD503201F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic [63:0] ifid_pc_plus4;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .pc            (pc),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .fetch_count   (fetch_count)
  );

  // Instruction memory image: word index tagged with 0xA in the top nibble.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // ---------------- reference model ----------------
  logic [63:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = BUBBLE;
  logic [63:0] m_ipc = '0;
  logic [63:0] m_ipc4 = '0;
  logic [31:0] m_cnt = '0;

  always @(posedge clk) begin
    logic [63:0] next_pc;
    if (rst) begin
      m_pc = 64'h0; m_valid = 1'b0; m_instr = BUBBLE;
      m_ipc = '0; m_ipc4 = '0; m_cnt = '0;
    end else begin
      if (redirect)   next_pc = redirect_pc & ~64'h3;
      else if (stall) next_pc = m_pc;
      else            next_pc = m_pc + 64'd4;
      if (redirect || flush) begin
        m_valid = 1'b0; m_instr = BUBBLE; m_ipc = '0; m_ipc4 = '0;
      end else if (!stall) begin
        m_valid = 1'b1; m_instr = mem_word(m_pc);
        m_ipc = m_pc; m_ipc4 = m_pc + 64'd4; m_cnt = m_cnt + 32'd1;
      end
      m_pc = next_pc;
    end
    chk_en = 1'b1;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_pc",         pc,            m_pc);
      check("m_imem_addr",  imem_addr,     m_pc);
      check("m_ifid_valid", {63'd0, ifid_valid}, {63'd0, m_valid});
      check("m_ifid_instr", {32'd0, ifid_instr}, {32'd0, m_instr});
      check("m_ifid_pc",    ifid_pc,       m_ipc);
      check("m_ifid_pc4",   ifid_pc_plus4, m_ipc4);
      check("m_fetch_cnt",  {32'd0, fetch_count}, {32'd0, m_cnt});
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic s, input logic f,
                      input logic rd, input logic [63:0] rpc);
    rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    check("rst_pc",    pc, 64'h0);
    check("rst_valid", {63'd0, ifid_valid}, 64'd0);
    check("rst_instr", {32'd0, ifid_instr}, {32'd0, BUBBLE});
    check("rst_cnt",   {32'd0, fetch_count}, 64'd0);

    // free run: first valid entry one edge after reset release
    run_idle(1);
    check("first_ifid_pc", ifid_pc, 64'h0);
    check("first_instr",   {32'd0, ifid_instr}, 64'hA000_0000);
    run_idle(1);
    check("run_pc", pc, 64'h8);

    // stall two cycles at pc=8
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    check("stall_pc",      pc, 64'h8);
    check("stall_ifid_pc", ifid_pc, 64'h4);
    check("stall_cnt",     {32'd0, fetch_count}, 64'd2);
    run_idle(1);
    check("resume_pc", pc, 64'hC);
    run_idle(1);
    check("run4_instr", {32'd0, ifid_instr}, 64'hA000_0003);
    check("run4_cnt",   {32'd0, fetch_count}, 64'd4);

    // redirect to 0x40
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h40);
    check("redir_pc",    pc, 64'h40);
    check("redir_valid", {63'd0, ifid_valid}, 64'd0);
    check("redir_instr", {32'd0, ifid_instr}, {32'd0, BUBBLE});
    run_idle(1);
    check("redir_tgt_pc",    ifid_pc, 64'h40);
    check("redir_tgt_valid", {63'd0, ifid_valid}, 64'd1);
    check("redir_tgt_instr", {32'd0, ifid_instr}, 64'hA000_0010);

    // redirect beats stall, low bits cleared
    step(1'b0, 1'b1, 1'b0, 1'b1, 64'h103);
    check("rs_pc",    pc, 64'h100);
    check("rs_valid", {63'd0, ifid_valid}, 64'd0);
    run_idle(1);

    // flush alone, then flush with stall
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h20);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    check("flush_pc",    pc, 64'h24);
    check("flush_valid", {63'd0, ifid_valid}, 64'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    check("fs_pc",    pc, 64'h24);
    check("fs_valid", {63'd0, ifid_valid}, 64'd0);
    check("fs_cnt",   {32'd0, fetch_count}, 64'd6);
    run_idle(1);
    check("post_flush_ifid_pc", ifid_pc, 64'h24);

    // wrap at top of address space
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    run_idle(1);
    check("wrap_pc",        pc, 64'h0);
    check("wrap_ifid_pc",   ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_ifid_pc4",  ifid_pc_plus4, 64'h0);
    run_idle(1);
    check("wrap_next_ifid", ifid_pc, 64'h0);

    // reset mid-stream with a pending redirect
    step(1'b1, 1'b0, 1'b0, 1'b1, 64'h80);
    check("mid_rst_pc",    pc, 64'h0);
    check("mid_rst_valid", {63'd0, ifid_valid}, 64'd0);
    check("mid_rst_cnt",   {32'd0, fetch_count}, 64'd0);
    check("mid_rst_pc4",   ifid_pc_plus4, 64'h0);
    run_idle(1);
    check("post_rst_cnt",  {32'd0, fetch_count}, 64'd1);

    // mixed control pattern, checked by the model only
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i[0], (i % 3) == 2, i == 5, 64'h200 + 64'(i));
    end
    run_idle(2);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
